taho_impuls_sched: RTL and testbench
====================================

# taho_impuls_sched

Timebase and readout scheduler for the tachometer and impulse measurement channels. It divides the 1 MHz system clock into the `msec` and `sec` gate strobes that drive the measurement units. One cycle after each `sec` strobe it snapshots the three 16-bit results `freq1`, `freq2` and `imp`, then sends them as a tagged three-word frame over a valid/ready stream. This stream is the single point through which the host/interface logic reads the measurement results.

## Interface
- `MS_DIV`, default 1000: clock cycles per `msec` strobe (≥2).
- `MS_PER_SEC`, default 1000: `msec` strobes per `sec` strobe (≥2).
- `clock`, in, 1: system clock, 1 MHz nominal.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `en`, in, 1: timebase enable; 0 holds both prescalers at 0 and stops strobes.
- `freq1`, in, 16: tacho 1 result, valid from the cycle after `sec`.
- `freq2`, in, 16: tacho 2 result, valid from the cycle after `sec`.
- `imp`, in, 16: impulse result, valid from the cycle after `msec`.
- `msec`, out, 1: one-cycle millisecond strobe.
- `sec`, out, 1: one-cycle second strobe; always coincident with a `msec`.
- `out_data`, out, 16: stream word.
- `out_tag`, out, 2: word identity: 0 = freq1, 1 = freq2, 2 = imp (3 is never driven).
- `out_last`, out, 1: high with the imp word.
- `out_valid`, out, 1: stream word valid.
- `out_ready`, in, 1: consumer accepts the word on a clock edge where `out_valid` and `out_ready` are both high.
- `ovr`, out, 1: sticky frame-overrun flag.
- `clr_ovr`, in, 1: synchronous clear of `ovr`.

## Operation
- Prescaler `ms_cnt`, range 0..MS_DIV-1:
  - Increments while `en`=1.
  - Wraps at MS_DIV-1; `msec` is registered high for the cycle after the wrap.
- Second counter `s_cnt`, range 0..MS_PER_SEC-1:
  - Advances on each `msec`.
  - `sec` is high together with the `msec` that wraps `s_cnt` from MS_PER_SEC-1 to 0.
- `en`=0 behaviour: both counters are held at 0 and no strobes are generated. On re-enable, the first `msec` comes MS_DIV cycles later.
- `sec_d` is `sec` delayed by one register stage.
- FSM states are IDLE, F1, F2, IMP.
  - IDLE + `sec_d`: load snapshots `s1`←freq1, `s2`←freq2, `si`←imp, and go to F1.
  - F1 presents {s1, tag 0}; F2 presents {s2, tag 1}; IMP presents {si, tag 2, last}.
  - Each state advances only on an accepted transfer: F1→F2→IMP→IDLE.
  - `out_valid` = (state ≠ IDLE). `out_data`, `out_tag` and `out_last` are decoded from the state and the snapshot registers. They stay stable while `out_valid`=1 and `out_ready`=0.
- Overrun:
  - Condition: `sec_d`=1 while the state ≠ IDLE, and the cycle is not the accepted final transfer (state IMP with `out_ready`=1).
  - Effect: `ovr` is set, the new snapshot is dropped, and the current frame continues unchanged.
- Back-to-back: if `sec_d`=1 in the same cycle as the accepted IMP transfer, the new snapshot loads and the state goes directly to F1. No bubble and no overrun.
- `clr_ovr` and a new overrun in the same cycle: set wins.
- Reset mid-frame: the frame is discarded, the state returns to IDLE and the snapshot registers clear to 0.

## Timing
- Reset values: `msec`, `sec`, `out_valid`, `out_last`, `ovr` = 0; `out_data` = 0; `out_tag` = 0; all counters 0; state IDLE.
- Strobe spacing:
  - `msec` period is exactly MS_DIV cycles.
  - `sec` period is exactly MS_DIV×MS_PER_SEC cycles.
  - The first `msec` after reset release is on cycle MS_DIV, counting the first enabled edge as cycle 1.
- Frame latency: `sec` in cycle T, `sec_d` in T+1, snapshot loads on the edge ending T+1. `out_valid` and tag 0 appear in T+2.
- With `out_ready` held at 1, the frame occupies cycles T+2, T+3 and T+4, and `out_valid` drops in T+5.
- Throughput is one word per cycle. Backpressure holds the word indefinitely, and `ovr` is the only loss indicator.

## Test plan
- **Strobes**: MS_DIV=4, MS_PER_SEC=3, `en`=1 after reset → `msec` on cycles 4, 8, 12, …; `sec` on cycles 12, 24, … only.
- **Nominal frame**: freq1=0x1234, freq2=0xABCD, imp=0x0042, `out_ready`=1 → words (0x1234, tag 0), (0xABCD, tag 1), (0x0042, tag 2, last) in T+2..T+4.
- **Backpressure**: `out_ready`=0 for 5 cycles in F2 → 0xABCD and tag 1 are held stable and `out_valid` stays 1. Release continues with the imp word.
- **Overrun**: MS_DIV=2, MS_PER_SEC=2, `out_ready`=0 → `ovr`=1 at the second `sec_d`, and the first frame's data is unchanged. `clr_ovr` pulse → `ovr`=0.
- **Back-to-back**: `sec_d` coincides with the accepted imp word → the next cycle shows tag 0 with the new freq1, and `ovr` stays 0.
- **Reset/enable**: assert `reset` during F2 → all outputs are 0 asynchronously and the state is IDLE. `en`=0 for 10 cycles → no strobes; re-enable → `msec` MS_DIV cycles later.

Source files
------------

// File: rtl/taho_impuls_sched.sv
// Timebase (msec/sec strobes) and tagged three-word readout of the freq1/freq2/imp results.
// A snapshot is taken one cycle after each sec strobe and streamed over valid/ready.
module taho_impuls_sched #(
  parameter int MS_DIV     = 1000,
  parameter int MS_PER_SEC = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] freq1,
  input  logic [15:0] freq2,
  input  logic [15:0] imp,
  output logic        msec,
  output logic        sec,
  output logic [15:0] out_data,
  output logic [1:0]  out_tag,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovr,
  input  logic        clr_ovr
);

  localparam int MSW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int SW  = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;

  typedef enum logic [1:0] {IDLE, F1, F2, IMP} state_t;

  state_t          state_q, state_d;
  logic [MSW-1:0]  ms_cnt_q, ms_cnt_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic            msec_q, msec_d;
  logic            sec_q, sec_d;
  logic            sec_dly_q, sec_dly_d;
  logic [15:0]     s1_q, s1_d, s2_q, s2_d, si_q, si_d;
  logic            ovr_q, ovr_d;
  logic            ms_wrap, s_wrap, load, final_acc;

  // Prescalers: the s_cnt wrap is decided on the same edge as the ms wrap so sec lines up with msec.
  always_comb begin
    ms_wrap   = (ms_cnt_q == MSW'(MS_DIV - 1));
    s_wrap    = (s_cnt_q == SW'(MS_PER_SEC - 1));
    ms_cnt_d  = '0;
    s_cnt_d   = '0;
    msec_d    = 1'b0;
    sec_d     = 1'b0;
    if (en) begin
      ms_cnt_d = ms_wrap ? '0 : ms_cnt_q + 1'b1;
      s_cnt_d  = s_cnt_q;
      msec_d   = ms_wrap;
      if (ms_wrap) begin
        s_cnt_d = s_wrap ? '0 : s_cnt_q + 1'b1;
        sec_d   = s_wrap;
      end
    end
    sec_dly_d = sec_q;
  end

  always_comb begin
    state_d   = state_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    si_d      = si_q;
    ovr_d     = ovr_q;
    load      = 1'b0;
    final_acc = (state_q == IMP) && out_ready;
    case (state_q)
      IDLE: if (sec_dly_q) load = 1'b1;
      F1:   if (out_ready) state_d = F2;
      F2:   if (out_ready) state_d = IMP;
      IMP:  if (out_ready) begin
              if (sec_dly_q) load = 1'b1;
              else           state_d = IDLE;
            end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = F1;
      s1_d    = freq1;
      s2_d    = freq2;
      si_d    = imp;
    end
    if (clr_ovr) ovr_d = 1'b0;
    // A snapshot arriving while a frame is still in flight is dropped; set beats clear.
    if (sec_dly_q && (state_q != IDLE) && !final_acc) ovr_d = 1'b1;
  end

  always_comb begin
    out_valid = (state_q != IDLE);
    out_data  = 16'h0000;
    out_tag   = 2'd0;
    out_last  = 1'b0;
    case (state_q)
      F1:  begin out_data = s1_q; out_tag = 2'd0; end
      F2:  begin out_data = s2_q; out_tag = 2'd1; end
      IMP: begin out_data = si_q; out_tag = 2'd2; out_last = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ms_cnt_q  <= '0;
      s_cnt_q   <= '0;
      msec_q    <= 1'b0;
      sec_q     <= 1'b0;
      sec_dly_q <= 1'b0;
      s1_q      <= 16'h0000;
      s2_q      <= 16'h0000;
      si_q      <= 16'h0000;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      s_cnt_q   <= s_cnt_d;
      msec_q    <= msec_d;
      sec_q     <= sec_d;
      sec_dly_q <= sec_dly_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      si_q      <= si_d;
      ovr_q     <= ovr_d;
    end
  end

  assign msec = msec_q;
  assign sec  = sec_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_taho_impuls_sched.sv
// Directed bench for taho_impuls_sched (MS_DIV=4, MS_PER_SEC=3) with a queue-based
// reference model checked every cycle plus hand-computed cycle/value checkpoints.
module tb_taho_impuls_sched;

  localparam int MS_DIV     = 4;
  localparam int MS_PER_SEC = 3;

  logic        clock, reset, en, out_ready, clr_ovr;
  logic [15:0] freq1, freq2, imp;
  logic        msec, sec, out_last, out_valid, ovr;
  logic [15:0] out_data;
  logic [1:0]  out_tag;

  taho_impuls_sched #(.MS_DIV(MS_DIV), .MS_PER_SEC(MS_PER_SEC)) u_dut (
    .clock(clock), .reset(reset), .en(en),
    .freq1(freq1), .freq2(freq2), .imp(imp),
    .msec(msec), .sec(sec),
    .out_data(out_data), .out_tag(out_tag), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .ovr(ovr), .clr_ovr(clr_ovr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  // Reference model: enabled-edge count gives strobes; a queue of pending words gives the stream.
  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  t;
    logic        l;
  } word_t;

  word_t q[$];
  int    en_cnt = 0;
  logic  m_msec = 0, m_sec = 0, m_secd = 0, m_ovr = 0;

  always @(posedge clock) begin
    logic r, e, rdy, c;
    logic [15:0] f1, f2, im;
    r = reset; e = en; rdy = out_ready; c = clr_ovr;
    f1 = freq1; f2 = freq2; im = imp;
    #1;
    if (r || reset) begin
      q.delete();
      en_cnt = 0; m_msec = 0; m_sec = 0; m_secd = 0; m_ovr = 0;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (c) m_ovr = 0;
      if (m_secd) begin
        if (q.size() == 0) begin
          q.push_back('{d: f1, t: 2'd0, l: 1'b0});
          q.push_back('{d: f2, t: 2'd1, l: 1'b0});
          q.push_back('{d: im, t: 2'd2, l: 1'b1});
        end else begin
          m_ovr = 1;
        end
      end
      m_secd = m_sec;
      if (e) begin
        en_cnt++;
        m_msec = (en_cnt % MS_DIV) == 0;
        m_sec  = (en_cnt % (MS_DIV * MS_PER_SEC)) == 0;
      end else begin
        en_cnt = 0; m_msec = 0; m_sec = 0;
      end
    end
    chk("msec", msec, m_msec);
    chk("sec", sec, m_sec);
    chk("ovr", ovr, m_ovr);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_tag", out_tag, q[0].t);
      chk("out_last", out_last, q[0].l);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; en = 0; out_ready = 1; clr_ovr = 0;
    freq1 = 16'h1234; freq2 = 16'hABCD; imp = 16'h0042;
    @(negedge clock); @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_msec", msec, 0);
    chk("rst_sec", sec, 0);
    reset = 0; en = 1;

    // Strobes
    for (int i = 0; i < 30 && !msec; i++) @(negedge clock);
    chk("first_msec_cyc", cyc, 4);
    for (int i = 0; i < 30 && !sec; i++) @(negedge clock);
    chk("first_sec_cyc", cyc, 12);

    // Nominal frame: sec at 12, words at 14..16
    for (int i = 0; i < 30 && !out_valid; i++) @(negedge clock);
    chk("frame_start_cyc", cyc, 14);
    chk("w0_data", out_data, 16'h1234);
    chk("w0_tag", out_tag, 0);
    @(negedge clock);
    chk("w1_data", out_data, 16'hABCD);
    chk("w1_tag", out_tag, 1);
    @(negedge clock);
    chk("w2_data", out_data, 16'h0042);
    chk("w2_tag", out_tag, 2);
    chk("w2_last", out_last, 1);
    @(negedge clock);
    chk("frame_end_valid", out_valid, 0);

    // Backpressure in F2 for five cycles; freq2 changes underneath
    wait_cyc(27);
    chk("bp_f2_tag", out_tag, 1);
    out_ready = 0; freq2 = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 16'hABCD);
      chk("bp_hold_tag", out_tag, 1);
    end
    out_ready = 1;
    @(negedge clock);
    chk("bp_release_tag", out_tag, 2);
    chk("bp_release_data", out_data, 16'h0042);

    // Back-to-back: IMP accepted on the edge where sec_d is high (sec at 60)
    wait_cyc(50);
    out_ready = 0;
    wait_cyc(59);
    out_ready = 1; freq1 = 16'h7777;
    wait_cyc(61);
    chk("b2b_imp_tag", out_tag, 2);
    wait_cyc(62);
    chk("b2b_next_tag", out_tag, 0);
    chk("b2b_next_data", out_data, 16'h7777);
    chk("b2b_no_ovr", ovr, 0);

    // Overrun: frame from sec 72 stalls, sec 84 snapshot dropped
    wait_cyc(74);
    out_ready = 0;
    wait_cyc(80);
    freq1 = 16'h9999;
    wait_cyc(85);
    chk("ovr_before", ovr, 0);
    wait_cyc(86);
    chk("ovr_set", ovr, 1);
    chk("ovr_keep_data", out_data, 16'h7777);
    chk("ovr_keep_tag", out_tag, 0);
    wait_cyc(87);
    clr_ovr = 1;
    wait_cyc(88);
    clr_ovr = 0;
    chk("ovr_cleared", ovr, 0);
    wait_cyc(97);
    clr_ovr = 1;
    wait_cyc(98);
    clr_ovr = 0;
    chk("ovr_set_wins", ovr, 1);
    wait_cyc(99);
    clr_ovr = 1;
    wait_cyc(100);
    clr_ovr = 0;
    chk("ovr_cleared2", ovr, 0);
    chk("ovr_frame_data", out_data, 16'h7777);
    out_ready = 1;

    // Reset during F2 (frame from sec 108)
    wait_cyc(111);
    chk("pre_rst_tag", out_tag, 1);
    chk("pre_rst_data", out_data, 16'h5555);
    reset = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_tag", out_tag, 0);
    chk("arst_last", out_last, 0);
    @(negedge clock); @(negedge clock);
    reset = 0;

    // Enable gating
    wait_cyc(5);
    en = 0;
    wait_cyc(15);
    en = 1;
    for (int i = 0; i < 30 && !msec; i++) @(negedge clock);
    chk("reenable_msec_cyc", cyc, 19);
    repeat (30) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
